// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// status bit positions and TX state encodings.
package mmio_uart_tx_pkg;

    localparam logic [31:0] UART_ADDR_TX     = 32'hFFFF_0000;
    localparam logic [31:0] UART_ADDR_STATUS = 32'hFFFF_0004;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_EMPTY = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic full,
                                                input logic ovf,
                                                input logic empty);
        logic [31:0] w;
        w             = '0;
        w[STAT_BUSY]  = busy;
        w[STAT_FULL]  = full;
        w[STAT_OVF]   = ovf;
        w[STAT_EMPTY] = empty;
        return w;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop frees the head slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO serial transmitter: decodes core stores, buffers TX bytes in a FIFO
// and shifts them out as 8N1 frames; exposes a pollable status register.
import mmio_uart_tx_pkg::*;

module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] ADDR_TX      = UART_ADDR_TX,
    parameter logic [31:0] ADDR_STATUS  = UART_ADDR_STATUS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] write_data,
    output logic        sel,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic          hit_tx;
    logic          hit_status;
    logic          push_req;
    logic          clr_req;
    logic          pop;
    logic          baud_last;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          unused_wdata_hi;

    assign hit_tx          = (mem_addr == ADDR_TX);
    assign hit_status      = (mem_addr == ADDR_STATUS);
    assign sel             = hit_tx || hit_status;
    assign push_req        = mem_write && hit_tx;
    assign clr_req         = mem_write && hit_status;
    assign unused_wdata_hi = ^write_data[31:8];

    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
    assign read_data = hit_status ? status_word(busy, fifo_full, ovf_q, fifo_empty)
                                  : 32'h0;
    assign tx        = tx_q;
    assign baud_last = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdata_i (write_data[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A dropped byte sets overflow even if software clears it on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_req) ovf_d = 1'b0;
        if (push_req && fifo_full && !pop) ovf_d = 1'b1;
    end

    // tx_d is the line level for the cycle after this edge, so tx stays a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    // The shift register is pure data; it is always reloaded before use.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: decode table, directed frame
// sequences, and randomized traffic against a cycle-level behavioural model.
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam logic [31:0] A_TX = 32'hFFFF_0000;
    localparam logic [31:0] A_ST = 32'hFFFF_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] write_data;
    logic        sel;
    logic [31:0] read_data;
    logic        tx;
    logic        busy;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .sel        (sel),
        .read_data  (read_data),
        .tx         (tx),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: byte queue, cycles left in the current frame, frame bits.
    logic [7:0] mq[$];
    int         remain;
    logic [9:0] mframe;
    logic       movf;

    logic       cap[$];
    logic [7:0] dec_bytes[$];
    int         dec_starts[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_sel;
        logic [31:0] exp_rd;
        logic        exp_busy;
        logic        exp_tx;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic b, f, e;
        b = (remain > 0) || (mq.size() > 0);
        f = (mq.size() == DEPTH);
        e = (mq.size() == 0);
        return {28'd0, e, movf, f, b};
    endfunction

    function automatic logic m_tx();
        if (remain == 0) return 1'b1;
        return mframe[(10 * CPB - remain) / CPB];
    endfunction

    task automatic model_reset();
        mq.delete();
        remain = 0;
        mframe = 10'h3FF;
        movf   = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic push, clr, pop, full, set;
        logic [7:0] b;
        push = we && (a == A_TX);
        clr  = we && (a == A_ST);
        full = (mq.size() == DEPTH);
        pop  = (remain == 0) && (mq.size() > 0);
        set  = 1'b0;
        if (pop) begin
            b = mq.pop_front();
            mframe = {1'b1, b, 1'b0};
        end
        if (push) begin
            if (!full || pop) mq.push_back(d[7:0]);
            else set = 1'b1;
        end
        if (set) movf = 1'b1;
        else if (clr) movf = 1'b0;
        if (pop) remain = 10 * CPB;
        else if (remain > 0) remain--;
    endtask

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
        mem_write  = we;
        mem_addr   = a;
        write_data = d;
        #1;
        chk("sel", {31'd0, sel}, {31'd0, (a == A_TX) || (a == A_ST)});
        chk("read_data", read_data, (a == A_ST) ? m_status() : 32'h0);
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        chk("tx", {31'd0, tx}, {31'd0, m_tx()});
        chk("busy", {31'd0, busy}, {31'd0, (remain > 0) || (mq.size() > 0)});
        cap.push_back(tx);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0);
    endtask

    task automatic peek(input string name, input logic [31:0] exp);
        mem_write = 1'b0;
        mem_addr  = A_ST;
        #1;
        chk(name, read_data, exp);
    endtask

    // Independent line decoder over the captured tx samples.
    task automatic decode();
        int i;
        logic [7:0] b;
        dec_bytes.delete();
        dec_starts.delete();
        i = 0;
        while (i + 39 < cap.size()) begin
            if (cap[i] == 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = cap[i + 4 * (j + 1) + 2];
                chk("stop_bit", {31'd0, cap[i + 38]}, 32'd1);
                dec_bytes.push_back(b);
                dec_starts.push_back(i);
                i += 40;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        logic [9:0] line55;
        logic [7:0] exp3[3];
        int burst;
        int r;
        logic [31:0] a;

        rst        = 1'b1;
        mem_write  = 1'b0;
        mem_addr   = 32'h0;
        write_data = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        mem_addr = A_ST;
        #1;
        chk("reset_status", read_data, 32'h8);
        rst = 1'b0;

        // Address decode table while idle.
        vt[0] = '{1'b0, A_TX,          32'h0,  1'b1, 32'h0, 1'b0, 1'b1};
        vt[1] = '{1'b0, A_ST,          32'h0,  1'b1, 32'h8, 1'b0, 1'b1};
        vt[2] = '{1'b1, 32'hFFFF_0008, 32'hAB, 1'b0, 32'h0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 32'h1001_0040, 32'h55, 1'b0, 32'h0, 1'b0, 1'b1};
        vt[4] = '{1'b0, 32'hFFFF_0008, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1};
        vt[5] = '{1'b1, A_ST,          32'h0,  1'b1, 32'h8, 1'b0, 1'b1};
        vt[6] = '{1'b0, 32'hFFFF_0005, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1};
        vt[7] = '{1'b0, 32'h0000_0000, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1};
        for (int v = 0; v < 8; v++) begin
            mem_write  = vt[v].we;
            mem_addr   = vt[v].addr;
            write_data = vt[v].data;
            #1;
            chk("tbl_sel", {31'd0, sel}, {31'd0, vt[v].exp_sel});
            chk("tbl_rd", read_data, vt[v].exp_rd);
            @(posedge clk);
            model_edge(vt[v].we, vt[v].addr, vt[v].data);
            #1;
            chk("tbl_busy", {31'd0, busy}, {31'd0, vt[v].exp_busy});
            chk("tbl_tx", {31'd0, tx}, {31'd0, vt[v].exp_tx});
        end
        peek("tbl_status_after", 32'h8);

        // Single 0x55 frame: exact line waveform.
        line55 = 10'b10_1010_1010;
        cap.delete();
        step(1'b1, A_TX, 32'h0000_0155);
        chk("latency_tx_high", {31'd0, cap[0]}, 32'd1);
        idle(41);
        for (int i = 0; i < 40; i++)
            chk("line55", {31'd0, cap[i + 1]}, {31'd0, line55[i / CPB]});
        chk("line55_idle", {31'd0, cap[41]}, 32'd1);
        chk("single_busy_end", {31'd0, busy}, 32'd0);

        // Three back-to-back stores.
        exp3[0] = 8'hA1; exp3[1] = 8'hB2; exp3[2] = 8'hC3;
        cap.delete();
        step(1'b1, A_TX, 32'hA1);
        step(1'b1, A_TX, 32'hB2);
        step(1'b1, A_TX, 32'hC3);
        peek("three_status", 32'h1);
        idle(125);
        decode();
        chk("three_count", dec_bytes.size(), 32'd3);
        if (dec_bytes.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("three_byte", {24'd0, dec_bytes[i]}, {24'd0, exp3[i]});
            chk("three_gap1", dec_starts[1] - dec_starts[0], 32'd41);
            chk("three_gap2", dec_starts[2] - dec_starts[1], 32'd41);
        end
        chk("three_busy_end", {31'd0, busy}, 32'd0);

        // Ten stores into an 8-deep FIFO, clear, and re-overflow.
        cap.delete();
        for (int i = 1; i <= 10; i++) step(1'b1, A_TX, 32'(i));
        peek("ten_status_full_ovf", 32'h7);
        step(1'b1, A_ST, 32'h0);
        peek("ten_status_cleared", 32'h3);
        step(1'b1, A_TX, 32'hEE);
        peek("ten_status_reovf", 32'h7);
        step(1'b1, A_ST, 32'h0);
        peek("ten_status_cleared2", 32'h3);
        idle(380);
        decode();
        chk("ten_count", dec_bytes.size(), 32'd9);
        if (dec_bytes.size() == 9)
            for (int i = 0; i < 9; i++) chk("ten_byte", {24'd0, dec_bytes[i]}, 32'(i + 1));
        peek("ten_status_idle", 32'h8);

        // Asynchronous reset 13 cycles into a frame, with bytes still queued.
        step(1'b1, A_TX, 32'h3C);
        step(1'b1, A_TX, 32'h5A);
        step(1'b1, A_TX, 32'h66);
        idle(11);
        mem_write = 1'b0;
        mem_addr  = A_ST;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", {31'd0, tx}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_status", read_data, 32'h8);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        // Randomized traffic against the model.
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) burst = ($urandom_range(0, 2) == 0) ? 1 : 0;
            r = $urandom_range(0, 99);
            if (r < (burst ? 60 : 4)) begin
                step(1'b1, A_TX, $urandom);
            end else if (r < (burst ? 63 : 6)) begin
                step(1'b1, A_ST, $urandom);
            end else if (r < (burst ? 67 : 9)) begin
                a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_0008 : ($urandom & 32'h7FFF_FFFC);
                step(1'b1, a, $urandom);
            end else if (r < (burst ? 72 : 14)) begin
                step(1'b0, A_ST, 32'h0);
            end else begin
                step(1'b0, 32'h0, 32'h0);
            end
        end
        idle(10 * 41 + 10);
        peek("final_status", m_status());
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped serial transmitter on the MIPS core's data-memory side. It consumes the core's store traffic (mem_addr, write_data, mem_write). Stores to the TX register are buffered in a small FIFO and shifted out as 8N1 UART frames. A status register is returned to the core's load mux so software can poll for free space and overflow.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (>=2).
FIFO_DEPTH, 8, TX byte buffer entries (power of two, >=2).
ADDR_TX, 32'hFFFF_0000, word address of the TX data register (write-only).
ADDR_STATUS, 32'hFFFF_0004, word address of the status register (read; write clears overflow).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
mem_write  in  1  core store strobe, valid for the current cycle
mem_addr  in  32  core data address
write_data  in  32  core store data; only bits [7:0] are used for TX
sel  out  1  combinational: 1 when mem_addr equals ADDR_TX or ADDR_STATUS
read_data  out  32  combinational: status word when mem_addr==ADDR_STATUS, else 0
tx  out  1  serial line, idle high
busy  out  1  1 while a frame is in progress or the FIFO is non-empty

Behaviour:
- Reset (async, any time, including mid-frame): FIFO empty, pointers 0, overflow=0, FSM=IDLE, baud counter 0, bit index 0, tx=1, busy=0. A partial frame is abandoned and the line returns high immediately.
- Status word: bit0=busy, bit1=fifo_full, bit2=overflow, bit3=fifo_empty, bits[31:4]=0.
- Push: at a clock edge with mem_write=1 and mem_addr==ADDR_TX:
  - FIFO not full: write_data[7:0] is enqueued.
  - FIFO full and no pop on that edge: byte is dropped and overflow is set (sticky).
  - Full with a simultaneous pop: push is accepted and overflow is unchanged.
- Clear: mem_write=1 with mem_addr==ADDR_STATUS clears overflow. If an overflow event occurs on the same edge, set wins.
- Other addresses are ignored, with no side effects.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, clear the baud counter, go to START. tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: STOP's last cycle returns to IDLE, which pops on the next edge. This gives exactly one extra idle-high cycle between frames, so each frame occupies 10*CLKS_PER_BIT+1 cycles when the FIFO is continuously non-empty.
- Latency: a store to TX at edge N into an empty FIFO with FSM idle is popped at edge N+1, so tx falls after edge N+1.
- tx is registered, driven from FSM state and the shift register with no combinational glitch path.
- Wrap-around: read and write pointers use log2(FIFO_DEPTH)+1 bits. full = MSBs differ and lower bits equal; empty = pointers equal.
- Baud counter is $clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1.

Decomposition:
- Shared package/header: ADDR_TX, ADDR_STATUS, status bit positions, FSM state encodings (2-bit localparams).
- One sub-module: sync_fifo (parameter WIDTH=8, DEPTH=FIFO_DEPTH; push/pop/full/empty/count). The top level holds address decode, the overflow flag and the TX FSM.

Test Plan:
- Reset mid-frame, with CLKS_PER_BIT=4 for all tests: assert rst 13 cycles into a frame -> tx=1 immediately, busy=0, read_data at ADDR_STATUS = 32'h8.
- Single store of 32'h0000_0155 to ADDR_TX -> tx falls after the next edge, then emits line bits 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop), 4 cycles each. busy=0 afterwards.
- Stores of 0xA1,0xB2,0xC3 on three consecutive cycles -> three frames in order, each 41 cycles apart with one idle cycle between them. Status reads 32'h1 mid-stream.
- Ten stores on consecutive cycles (DEPTH=8; the first is popped at once) -> bytes 1-9 transmitted, the 10th dropped. Status = 32'h7 (busy, full, overflow) while full.
- Store to ADDR_STATUS -> overflow cleared. A simultaneous clear and overflow-drop on the same edge -> overflow stays 1.
- Store to 32'hFFFF_0008 and an ordinary RAM address -> sel=0, read_data=0, no FIFO change, tx stays high.
